// File: rtl/serial_frame_rx.sv
// serial_frame_rx
//   Trigger-started, fixed-rate, MSB-first serial frame receiver. A frame is
//   an HS_W-bit start handshake, then N_WORDS words of WORD_W bits, then an
//   HS_W-bit end handshake. When both handshakes match their expected values,
//   the outputs are updated from the shadow register in a single edge.
//
//   Optional build macro SERIAL_FRAME_RX_MAJ3_EN:
//     Each bit is the 2-of-3 majority of samples taken at SAMPLE_AT-1,
//     SAMPLE_AT and SAMPLE_AT+1. The bit is shifted in at SAMPLE_AT+1.
//     Frame timing is the same in both builds.
//
// Ports
//   clk_in      : clock
//   rst_in      : asynchronous active-high reset
//   in          : serial data (asynchronous, 2-FF synchronised)
//   trig_in     : frame trigger (asynchronous, 2-FF synchronised, rising edge)
//   handshake_i : last accepted start handshake
//   handshake_f : last accepted end handshake
//   words       : last accepted words, word k at [k*WORD_W +: WORD_W]
//   frame_stb   : one-cycle pulse at the end of every frame
//   frame_ok    : handshake check result of the last frame
//   busy        : frame capture in progress (RX or DONE)
//   trig_ovr    : sticky, trigger edge seen while busy
module serial_frame_rx #(
  parameter int unsigned            BIT_CLKS  = 1000,
  parameter int unsigned            SAMPLE_AT = 500,
  parameter int unsigned            WORD_W    = 35,
  parameter int unsigned            N_WORDS   = 27,
  parameter int unsigned            HS_W      = 16,
  parameter logic [HS_W-1:0]        HS_I_EXP  = 16'hAAAA,
  parameter logic [HS_W-1:0]        HS_F_EXP  = 16'h5555
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      in,
  input  logic                      trig_in,
  output logic [HS_W-1:0]           handshake_i,
  output logic [HS_W-1:0]           handshake_f,
  output logic [N_WORDS*WORD_W-1:0] words,
  output logic                      frame_stb,
  output logic                      frame_ok,
  output logic                      busy,
  output logic                      trig_ovr
);

  localparam int unsigned FRAME_BITS = 2*HS_W + N_WORDS*WORD_W;
  localparam int unsigned CW = $clog2(BIT_CLKS);
  localparam int unsigned BW = $clog2(FRAME_BITS+1);

  localparam logic [CW-1:0] C_LAST   = CW'(BIT_CLKS-1);
  localparam logic [BW-1:0] B_LAST   = BW'(FRAME_BITS-1);
`ifdef SERIAL_FRAME_RX_MAJ3_EN
  localparam logic [CW-1:0] C_PRE    = CW'(SAMPLE_AT-1);
  localparam logic [CW-1:0] C_MID    = CW'(SAMPLE_AT);
  localparam logic [CW-1:0] C_SHIFT  = CW'(SAMPLE_AT+1);
`else
  localparam logic [CW-1:0] C_SHIFT  = CW'(SAMPLE_AT);
`endif

  typedef enum logic [1:0] {S_IDLE, S_RX, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             c_q;
  logic [BW-1:0]             b_q;
  logic [FRAME_BITS-1:0]     shadow;
  logic                      in_s1, in_s, trig_s1, trig_s, trig_s_d;
  logic                      start, bit_last, bit_val, hs_ok;
  logic [N_WORDS*WORD_W-1:0] words_d;

  // Both inputs see the same two-stage latency; trig_s_d only feeds the
  // edge detector and adds no latency to the trigger path.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      in_s1    <= 1'b0;
      in_s     <= 1'b0;
      trig_s1  <= 1'b0;
      trig_s   <= 1'b0;
      trig_s_d <= 1'b0;
    end else begin
      in_s1    <= in;
      in_s     <= in_s1;
      trig_s1  <= trig_in;
      trig_s   <= trig_s1;
      trig_s_d <= trig_s;
    end
  end

  assign start    = trig_s & ~trig_s_d;
  assign bit_last = (c_q == C_LAST);
  assign busy     = (state_q != S_IDLE);

`ifdef SERIAL_FRAME_RX_MAJ3_EN
  logic s_pre, s_mid;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s_pre <= 1'b0;
      s_mid <= 1'b0;
    end else if (state_q == S_RX) begin
      if (c_q == C_PRE) s_pre <= in_s;
      if (c_q == C_MID) s_mid <= in_s;
    end
  end

  // Third vote is the live sample at SAMPLE_AT+1.
  assign bit_val = (s_pre & s_mid) | (s_pre & in_s) | (s_mid & in_s);
`else
  assign bit_val = in_s;
`endif

  assign hs_ok = (shadow[FRAME_BITS-1 -: HS_W] == HS_I_EXP) &&
                 (shadow[HS_W-1:0] == HS_F_EXP);

  // Word 0 arrives first, so it sits just below the start handshake.
  always_comb begin
    words_d = '0;
    for (int unsigned k = 0; k < N_WORDS; k++) begin
      words_d[k*WORD_W +: WORD_W] = shadow[FRAME_BITS-HS_W-1-k*WORD_W -: WORD_W];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RX;
      S_RX:    if (bit_last && (b_q == B_LAST)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      c_q         <= '0;
      b_q         <= '0;
      shadow      <= '0;
      handshake_i <= '0;
      handshake_f <= '0;
      words       <= '0;
      frame_stb   <= 1'b0;
      frame_ok    <= 1'b0;
      trig_ovr    <= 1'b0;
    end else begin
      frame_stb <= 1'b0;
      if (start && (state_q != S_IDLE)) trig_ovr <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            c_q <= '0;
            b_q <= '0;
          end
        end
        S_RX: begin
          if (c_q == C_SHIFT) shadow <= {shadow[FRAME_BITS-2:0], bit_val};
          if (bit_last) begin
            c_q <= '0;
            b_q <= b_q + BW'(1);
          end else begin
            c_q <= c_q + CW'(1);
          end
        end
        S_DONE: begin
          frame_stb <= 1'b1;
          frame_ok  <= hs_ok;
          if (hs_ok) begin
            handshake_i <= shadow[FRAME_BITS-1 -: HS_W];
            handshake_f <= shadow[HS_W-1:0];
            words       <= words_d;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
module tb_serial_frame_rx;

  localparam int unsigned BC = 10;
  localparam int unsigned FB = 24;

  localparam int M_NORM   = 0;
  localparam int M_RETRIG = 1;
  localparam int M_HOLD   = 2;
  localparam int M_GLITCH = 3;
  localparam int M_RESET  = 4;

  // Edge index (counted from the edge after which trig_in rises) where
  // frame_stb is first seen high: t0 is edge 3, stb follows t0+241.
  localparam int STB_EDGE = 3 + 241;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        in = 1'b0;
  logic        trig_in = 1'b0;
  logic [3:0]  handshake_i, handshake_f;
  logic [15:0] words;
  logic        frame_stb, frame_ok, busy, trig_ovr;

  int n_cmp = 0;
  int n_bad = 0;

  serial_frame_rx #(
    .BIT_CLKS (10),
    .SAMPLE_AT(5),
    .WORD_W   (8),
    .N_WORDS  (2),
    .HS_W     (4),
    .HS_I_EXP (4'hA),
    .HS_F_EXP (4'h5)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .in         (in),
    .trig_in    (trig_in),
    .handshake_i(handshake_i),
    .handshake_f(handshake_f),
    .words      (words),
    .frame_stb  (frame_stb),
    .frame_ok   (frame_ok),
    .busy       (busy),
    .trig_ovr   (trig_ovr)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [23:0] frame;
    int          mode;
    logic        exp_ok;
    logic [15:0] exp_words;
    logic [3:0]  exp_hsi;
    logic [3:0]  exp_hsf;
    logic        exp_ovr;
  } vec_t;

  vec_t tbl [5];

  // Frame bits are {start HS, word0, word1, end HS}, sent MSB first.
  // Each bit is driven for BC cycles starting after edge 2, so the
  // synchronised value is stable across the sampling point.
  task automatic send_frame(input logic [23:0] fr, input int mode,
                            output int stb_cnt, output int stb_at,
                            output logic busy_mid);
    stb_cnt  = 0;
    stb_at   = -1;
    busy_mid = 1'b0;
    @(posedge clk_in); #1; trig_in = 1'b1;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    for (int i = 0; i < int'(FB*BC); i++) begin
      if (mode == M_RESET && i == 120) begin
        rst_in = 1'b1;
        #1;
        return;
      end
      in = fr[23 - i/10] ^ ((mode == M_GLITCH && i == 4) ? 1'b1 : 1'b0);
      if (mode != M_HOLD && i == 20) trig_in = 1'b0;
      if (mode == M_RETRIG && i == 70) trig_in = 1'b1;
      if (mode == M_RETRIG && i == 75) trig_in = 1'b0;
      if (i == 100) busy_mid = busy;
      @(posedge clk_in); #1;
    end
    for (int k = 3 + int'(FB*BC); k < 13 + int'(FB*BC); k++) begin
      @(posedge clk_in); #1;
      if (frame_stb) begin
        stb_cnt++;
        if (stb_cnt == 1) stb_at = k;
      end
    end
  endtask

  task automatic chk_frame(input string tag, input int cnt, input int at, input logic bm,
                           input logic e_ok, input logic [15:0] e_w,
                           input logic [3:0] e_hi, input logic [3:0] e_hf, input logic e_ovr);
    chk({tag, " stb_count"}, 32'(cnt), 32'd1);
    chk({tag, " stb_edge"}, 32'(at), 32'(STB_EDGE));
    chk({tag, " busy_mid"}, 32'(bm), 32'd1);
    chk({tag, " frame_ok"}, 32'(frame_ok), 32'(e_ok));
    chk({tag, " words"}, 32'(words), 32'(e_w));
    chk({tag, " hs_i"}, 32'(handshake_i), 32'(e_hi));
    chk({tag, " hs_f"}, 32'(handshake_f), 32'(e_hf));
    chk({tag, " trig_ovr"}, 32'(trig_ovr), 32'(e_ovr));
    chk({tag, " busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int   cnt, at, extra_stb, extra_busy;
    logic bm;

    tbl[0] = '{24'hA3CF15, M_NORM,   1'b1, 16'hF13C, 4'hA, 4'h5, 1'b0};
    tbl[1] = '{24'hA11224, M_NORM,   1'b0, 16'hF13C, 4'hA, 4'h5, 1'b0};
    tbl[2] = '{24'hA55665, M_RETRIG, 1'b1, 16'h6655, 4'hA, 4'h5, 1'b1};
    tbl[3] = '{24'hA12345, M_HOLD,   1'b1, 16'h3412, 4'hA, 4'h5, 1'b1};
`ifdef SERIAL_FRAME_RX_MAJ3_EN
    tbl[4] = '{24'hA77885, M_GLITCH, 1'b1, 16'h8877, 4'hA, 4'h5, 1'b1};
`else
    tbl[4] = '{24'hA77885, M_GLITCH, 1'b0, 16'h3412, 4'hA, 4'h5, 1'b1};
`endif

    repeat (3) @(posedge clk_in);
    #1;
    chk("reset words", 32'(words), 32'd0);
    chk("reset hs_i", 32'(handshake_i), 32'd0);
    chk("reset hs_f", 32'(handshake_f), 32'd0);
    chk("reset stb_ok_busy_ovr", 32'({frame_stb, frame_ok, busy, trig_ovr}), 32'd0);
    rst_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;

    for (int v = 0; v < 5; v++) begin
      send_frame(tbl[v].frame, tbl[v].mode, cnt, at, bm);
      chk_frame($sformatf("vec%0d", v), cnt, at, bm, tbl[v].exp_ok, tbl[v].exp_words,
                tbl[v].exp_hsi, tbl[v].exp_hsf, tbl[v].exp_ovr);
      if (tbl[v].mode == M_HOLD) begin
        // Trigger still high: no new edge, so no further capture.
        extra_stb  = 0;
        extra_busy = 0;
        for (int k = 0; k < 300; k++) begin
          @(posedge clk_in); #1;
          if (frame_stb) extra_stb++;
          if (busy) extra_busy++;
        end
        chk("hold stb_count", 32'(extra_stb), 32'd0);
        chk("hold busy_count", 32'(extra_busy), 32'd0);
        trig_in = 1'b0;
      end
      repeat (5) @(posedge clk_in);
      #1;
    end

    // Reset mid-frame at bit 12: outputs clear without waiting for a clock.
    send_frame(24'hA99995, M_RESET, cnt, at, bm);
    chk("midrst words", 32'(words), 32'd0);
    chk("midrst hs_i", 32'(handshake_i), 32'd0);
    chk("midrst hs_f", 32'(handshake_f), 32'd0);
    chk("midrst stb_ok_busy_ovr", 32'({frame_stb, frame_ok, busy, trig_ovr}), 32'd0);
    @(posedge clk_in); #1;
    rst_in  = 1'b0;
    trig_in = 1'b0;
    repeat (5) @(posedge clk_in);
    #1;
    send_frame(24'hA3CF15, M_NORM, cnt, at, bm);
    chk_frame("after_rst", cnt, at, bm, 1'b1, 16'hF13C, 4'hA, 4'h5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
